regfile_sb: RTL

Parametrised register file for the MIPS datapath, extending the 32x32 register file with configurable width and depth, a sequenced reset-time initialiser, and a per-register pending-write scoreboard. It sits between decode (read ports, scoreboard set) and writeback (write port, scoreboard clear). It drives a `stall` output that the hazard unit uses for load-use and long-latency interlocks.

---
 rtl/regfile_sb_if.sv | 32 +++
 rtl/regfile_sb.sv | 118 +++++++++++
 2 files changed

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bundle for the scoreboarded register file.
// The master side (decode and writeback) drives requests; the register file is the slave.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              rd_use1;
    logic              rd_use2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic              stall;
    logic              init_busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, rd_use1, rd_use2,
               sb_set, sb_addr,
        input  rd_data1, rd_data2, stall, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, rd_use1, rd_use2,
               sb_set, sb_addr,
        output rd_data1, rd_data2, stall, init_busy
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2R1W register file with a sequenced reset-time
// initialiser and a per-register pending-write scoreboard driving stall.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding of data
// and stall in the same cycle). Without it, reads see only stored values.
module regfile_sb #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int INIT_MODE = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]          state;
    logic [ADDR_W-1:0]   idx;
    logic [NUM_REGS-1:0] pending;
    logic [DATA_W-1:0]   rf [NUM_REGS];

    logic              run;
    logic              wr_ok;
    logic              set_ok;
    logic              last_idx;
    logic [DATA_W-1:0] init_val;
    logic              pend1;
    logic              pend2;

    assign run      = (state == S_RUN);
    // Register 0 is hardwired: its writes and scoreboard sets are dropped here.
    assign wr_ok    = run && bus.wr_en  && (bus.wr_addr != '0);
    assign set_ok   = run && bus.sb_set && (bus.sb_addr != '0);
    assign last_idx = (idx == ADDR_W'(NUM_REGS - 1));

    // Init pattern: either all zero or each register holding its own index.
    always_comb begin
        init_val = '0;
        if (INIT_MODE == 1) init_val = DATA_W'(idx);
    end

    // INIT walks idx across every register once, then hands over to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
            idx   <= '0;
        end else if (state == S_INIT) begin
            idx <= idx + 1'b1;
            if (last_idx) state <= S_RUN;
        end
    end

    // Scoreboard: the set is assigned after the clear so a same-edge set of the
    // written register wins, keeping the newer producer outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (wr_ok)  pending[bus.wr_addr] <= 1'b0;
            if (set_ok) pending[bus.sb_addr] <= 1'b1;
        end
    end

    // Storage: the initialiser owns the array in INIT, writeback owns it in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_INIT) rf[idx] <= init_val;
            else if (wr_ok)      rf[bus.wr_addr] <= bus.wr_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic hit1;
    logic hit2;
    logic set_same;

    assign hit1     = wr_ok && (bus.wr_addr == bus.rd_addr1);
    assign hit2     = wr_ok && (bus.wr_addr == bus.rd_addr2);
    // A newer producer issued against the written register keeps it pending.
    assign set_same = set_ok && (bus.sb_addr == bus.wr_addr);

    // Read port 1 with forwarding of the in-flight writeback value.
    always_comb begin
        bus.rd_data1 = '0;
        if (run && bus.rd_addr1 != '0) bus.rd_data1 = rf[bus.rd_addr1];
        if (hit1) bus.rd_data1 = bus.wr_data;
    end

    // Read port 2 with forwarding of the in-flight writeback value.
    always_comb begin
        bus.rd_data2 = '0;
        if (run && bus.rd_addr2 != '0) bus.rd_data2 = rf[bus.rd_addr2];
        if (hit2) bus.rd_data2 = bus.wr_data;
    end

    assign pend1 = bus.rd_use1 && pending[bus.rd_addr1] && !(hit1 && !set_same);
    assign pend2 = bus.rd_use2 && pending[bus.rd_addr2] && !(hit2 && !set_same);
`else
    // Read port 1: stored value only; register 0 and INIT read as zero.
    always_comb begin
        bus.rd_data1 = '0;
        if (run && bus.rd_addr1 != '0) bus.rd_data1 = rf[bus.rd_addr1];
    end

    // Read port 2: stored value only; register 0 and INIT read as zero.
    always_comb begin
        bus.rd_data2 = '0;
        if (run && bus.rd_addr2 != '0) bus.rd_data2 = rf[bus.rd_addr2];
    end

    assign pend1 = bus.rd_use1 && pending[bus.rd_addr1];
    assign pend2 = bus.rd_use2 && pending[bus.rd_addr2];
`endif

    assign bus.stall     = run && (pend1 || pend2);
    assign bus.init_busy = !run;
endmodule
